// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the handshaked pipeline stage registers:
// occupancy/state encoding, the RISC-V NOP bubble, and a sample F->D payload.
package pipe_stage_hs_pkg;

  localparam int unsigned ST_W = 2;

  // State encoding doubles as the held-entry count
  localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [ST_W-1:0] ST_ONE   = 2'd1;
  localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
  } fd_payload_t;

  localparam int unsigned FD_W = $bits(fd_payload_t);

  localparam fd_payload_t FD_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with synchronous reset to a fixed value and a load enable.
module pipe_data_reg #(
  parameter int unsigned     W       = 32,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage: 2-entry skid buffer with registered in_ready
// (SKID=1) or a single entry with combinational ready (SKID=0).
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned        DATA_W     = 96,
  parameter bit                 SKID       = 1'b1,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              push;
  logic              pop;
  logic              m_load;
  logic              m_clear;
  logic [DATA_W-1:0] m_din;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Main register drives out_data directly; clearing it yields the bubble
  pipe_data_reg #(
    .W       (DATA_W),
    .RST_VAL (BUBBLE_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst | m_clear),
    .load (m_load),
    .d    (m_din),
    .q    (out_data)
  );

  if (SKID) begin : gen_skid

    logic [ST_W-1:0]   state_q;
    logic [ST_W-1:0]   state_d;
    logic              rdy_q;
    logic              vld_q;
    logic              s_load;
    logic              m_from_s;
    logic [DATA_W-1:0] s_q;

    pipe_data_reg #(
      .W       (DATA_W),
      .RST_VAL (BUBBLE_VAL)
    ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (s_load),
      .d    (in_data),
      .q    (s_q)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_EMPTY;
        rdy_q   <= 1'b1;
        vld_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        rdy_q   <= (state_d != ST_FULL);
        vld_q   <= (state_d != ST_EMPTY);
      end
    end

    // Flush wins over push; a same-cycle pop needs no extra action here
    always_comb begin
      state_d  = state_q;
      m_load   = 1'b0;
      m_clear  = 1'b0;
      m_from_s = 1'b0;
      s_load   = 1'b0;
      if (clr) begin
        state_d = ST_EMPTY;
        m_clear = 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (push) begin
              state_d = ST_ONE;
              m_load  = 1'b1;
            end
          end
          ST_ONE: begin
            if (push && !pop) begin
              state_d = ST_FULL;
              s_load  = 1'b1;
            end else if (push && pop) begin
              m_load  = 1'b1;
            end else if (pop) begin
              state_d = ST_EMPTY;
              m_clear = 1'b1;
            end
          end
          ST_FULL: begin
            if (pop) begin
              state_d  = ST_ONE;
              m_load   = 1'b1;
              m_from_s = 1'b1;
            end
          end
          default: begin
            state_d = ST_EMPTY;
            m_clear = 1'b1;
          end
        endcase
      end
    end

    assign m_din     = m_from_s ? s_q : in_data;
    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign occupancy = state_q;

  end else begin : gen_single

    logic vld_q;
    logic vld_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_d;
      end
    end

    always_comb begin
      vld_d   = vld_q;
      m_load  = 1'b0;
      m_clear = 1'b0;
      if (clr) begin
        vld_d   = 1'b0;
        m_clear = 1'b1;
      end else if (push) begin
        vld_d  = 1'b1;
        m_load = 1'b1;
      end else if (pop) begin
        vld_d   = 1'b0;
        m_clear = 1'b1;
      end
    end

    assign m_din     = in_data;
    assign in_ready  = ~vld_q | out_ready;
    assign out_valid = vld_q;
    assign occupancy = {1'b0, vld_q};

  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: a SKID=1 and a SKID=0 instance, each
// checked every cycle against an in-order FIFO model of held entries.
module tb_pipe_stage_hs;
  import pipe_stage_hs_pkg::*;

  localparam logic [31:0] BUB = NOP_INSTR;

  logic        clk;
  logic        rst;
  logic        clr  [2];
  logic        iv   [2];
  logic        ir   [2];
  logic [31:0] id   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [31:0] od   [2];
  logic [1:0]  occ  [2];

  int nchk = 0;
  int nerr = 0;

  // Model: ring of held entries per instance
  logic [31:0] mq [2][4];
  int          head [2];
  int          cnt  [2];
  int          npop [2];
  int          max_occ;
  bit          dead_seen;
  logic [31:0] dlv [$];

  pipe_stage_hs #(.DATA_W(32), .SKID(1'b1), .BUBBLE_VAL(BUB)) dut_skid (
    .clk(clk), .rst(rst), .clr(clr[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .occupancy(occ[0])
  );

  pipe_stage_hs #(.DATA_W(32), .SKID(1'b0), .BUBBLE_VAL(BUB)) dut_single (
    .clk(clk), .rst(rst), .clr(clr[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .occupancy(occ[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, k, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one instance against the model, then apply this cycle's transfers
  task automatic model_step(input int k);
    logic exp_ir;
    if (rst) begin
      cnt[k]  = 0;
      head[k] = 0;
      return;
    end
    exp_ir = (k == 0) ? (cnt[k] < 2) : (cnt[k] == 0 || ordy[k]);
    chk("in_ready", k, 32'(ir[k]), 32'(exp_ir));
    chk("out_valid", k, 32'(ov[k]), 32'(cnt[k] != 0));
    chk("occupancy", k, 32'(occ[k]), cnt[k]);
    chk("out_data", k, od[k], (cnt[k] != 0) ? mq[k][head[k]] : BUB);
    if (k == 0) begin
      if (cnt[k] > max_occ) max_occ = cnt[k];
      if (ov[k] && od[k] == 32'hDEAD) dead_seen = 1'b1;
    end
    if (ov[k] && ordy[k] && cnt[k] != 0) begin
      if (k == 0) dlv.push_back(mq[k][head[k]]);
      head[k] = (head[k] + 1) % 4;
      cnt[k]--;
      npop[k]++;
    end
    if (clr[k]) begin
      cnt[k] = 0;
    end else if (iv[k] && ir[k] && cnt[k] < 4) begin
      mq[k][(head[k] + cnt[k]) % 4] = id[k];
      cnt[k]++;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // Offer one payload, holding it until accepted (bounded)
  task automatic send(input int k, input logic [31:0] d);
    int n;
    n = 0;
    iv[k] = 1'b1;
    id[k] = d;
    while (!ir[k] && n < 50) begin
      tick();
      n++;
    end
    if (!ir[k]) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout dut%0d actual=in_ready_low required=accept", k);
    end
    tick();
    iv[k] = 1'b0;
    id[k] = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    max_occ = 0;
    dead_seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b1; id[k] = $urandom; ordy[k] = 1'b0; clr[k] = 1'b0;
      head[k] = 0; cnt[k] = 0; npop[k] = 0;
    end

    // Reset with in_valid held high
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) iv[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
      chk("rst_occupancy", k, 32'(occ[k]), 32'd0);
      chk("rst_out_data", k, od[k], BUB);
      chk("rst_in_ready", k, 32'(ir[k]), 32'd1);
    end
    tick();

    // Streaming 1..8 back to back
    max_occ = 0;
    ordy[0] = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      send(0, 32'(v));
      chk("stream_data", 0, od[0], 32'(v));
      chk("stream_valid", 0, 32'(ov[0]), 32'd1);
    end
    repeat (3) tick();
    chk("stream_max_occ", 0, 32'(max_occ), 32'd1);

    // Back-pressure: A shown, B absorbed into skid, C held upstream
    dlv.delete();
    send(0, 32'hA);
    ordy[0] = 1'b0;
    send(0, 32'hB);
    iv[0] = 1'b1;
    id[0] = 32'hC;
    chk("bp_in_ready", 0, 32'(ir[0]), 32'd0);
    chk("bp_occ", 0, 32'(occ[0]), 32'd2);
    repeat (2) tick();
    chk("bp_hold_data", 0, od[0], 32'hA);
    chk("bp_hold_ready", 0, 32'(ir[0]), 32'd0);
    ordy[0] = 1'b1;
    for (int n = 0; n < 10 && !ir[0]; n++) tick();
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    chk("bp_count", 0, 32'(dlv.size()), 32'd3);
    if (dlv.size() >= 3) begin
      chk("bp_order0", 0, dlv[0], 32'hA);
      chk("bp_order1", 0, dlv[1], 32'hB);
      chk("bp_order2", 0, dlv[2], 32'hC);
    end

    // Flush while full, with a competing push of 0xDEAD
    ordy[0] = 1'b0;
    send(0, 32'h1);
    send(0, 32'h2);
    chk("flush_pre_occ", 0, 32'(occ[0]), 32'd2);
    dead_seen = 1'b0;
    clr[0] = 1'b1; iv[0] = 1'b1; id[0] = 32'hDEAD;
    tick();
    clr[0] = 1'b0; iv[0] = 1'b0;
    chk("flush_valid", 0, 32'(ov[0]), 32'd0);
    chk("flush_occ", 0, 32'(occ[0]), 32'd0);
    chk("flush_data", 0, od[0], BUB);
    chk("flush_ready", 0, 32'(ir[0]), 32'd1);
    ordy[0] = 1'b1;
    repeat (3) tick();
    chk("flush_no_dead", 0, 32'(dead_seen), 32'd0);

    // Simultaneous push and pop in ONE
    dlv.delete();
    ordy[0] = 1'b0;
    send(0, 32'h5);
    ordy[0] = 1'b1; iv[0] = 1'b1; id[0] = 32'h6;
    tick();
    iv[0] = 1'b0;
    chk("pp_data", 0, od[0], 32'h6);
    chk("pp_occ", 0, 32'(occ[0]), 32'd1);
    chk("pp_popped", 0, (dlv.size() > 0) ? dlv[0] : 32'hFFFF_FFFF, 32'h5);
    repeat (2) tick();

    // Single-entry build: ready follows out_ready combinationally
    ordy[1] = 1'b0;
    send(1, 32'h77);
    chk("single_ready_stall", 1, 32'(ir[1]), 32'd0);
    ordy[1] = 1'b1;
    #1;
    chk("single_ready_go", 1, 32'(ir[1]), 32'd1);
    tick();

    // Random traffic on both instances
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 9) < 7);
        id[k]   = $urandom;
        ordy[k] = ($urandom_range(0, 9) < 6);
        clr[k]  = ($urandom_range(0, 49) == 0);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; clr[k] = 1'b0; ordy[k] = 1'b1;
    end
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      chk("drain_empty", k, 32'(cnt[k]), 32'd0);
      chk("drain_valid", k, 32'(ov[k]), 32'd0);
      chk("traffic_seen", k, 32'(npop[k] > 1000), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
